// File: rtl/ex_time_ctrl.sv
// ex_time_ctrl: exposure-time setting controller.
//
// Holds the exposure setting that the user adjusts with the increment and decrement
// buttons. Steps saturate at MIN/MAX. A held button steps once, waits REPEAT_DELAY
// cycles, then repeats every REPEAT_PERIOD cycles. While `lock` is high the setting is
// frozen. After the lock drops, a button that is still held must be released before it
// takes effect again.
//
// Optional feature: define EX_TIME_ACCEL_EN to double the step size after ACCEL_AFTER
// unit repeat steps of one continuous hold.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   exp_inc  in   increment button (level, debounced)
//   exp_dec  in   decrement button (level, debounced)
//   recall   in   single-cycle request to load DEFAULT
//   lock     in   exposure/readout in progress; freezes the setting
//   ex_time  out  current setting, registered
//   at_min   out  ex_time == MIN
//   at_max   out  ex_time == MAX
//   changed  out  registered one-cycle pulse after ex_time takes a new value
module ex_time_ctrl #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned MIN           = 2,
  parameter int unsigned MAX           = 30,
  parameter int unsigned DEFAULT       = 15,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 2,
  parameter int unsigned ACCEL_AFTER   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exp_inc,
  input  logic             exp_dec,
  input  logic             recall,
  input  logic             lock,
  output logic [WIDTH-1:0] ex_time,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int unsigned TimerMax =
      (REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned TimerW = (TimerMax < 1) ? 1 : $clog2(TimerMax + 1);

  localparam logic [TimerW-1:0] DelayLoad  = TimerW'(REPEAT_DELAY - 1);
  localparam logic [TimerW-1:0] PeriodLoad = TimerW'(REPEAT_PERIOD - 1);

  // Arithmetic is done one bit wider than ex_time so +2 / -2 never wraps.
  localparam logic [WIDTH:0]   MinW     = (WIDTH + 1)'(MIN);
  localparam logic [WIDTH:0]   MaxW     = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH-1:0] MinV     = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MaxV     = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] DefaultV = WIDTH'(DEFAULT);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StLocked} state_e;
  typedef enum logic [1:0] {DirNone, DirUp, DirDn} dir_e;

  state_e            state_q, state_d;
  dir_e              dir, dir_q, dir_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [WIDTH-1:0]  ex_q, ex_d;
  logic              changed_q;
  logic              do_step;
  logic [WIDTH:0]    step_sz;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;

`ifdef EX_TIME_ACCEL_EN
  localparam int unsigned AccelW = (ACCEL_AFTER < 1) ? 1 : $clog2(ACCEL_AFTER + 1);
  localparam logic [AccelW-1:0] AccelMax = AccelW'(ACCEL_AFTER);

  logic [AccelW-1:0] accel_q, accel_d;
`endif

  // Simultaneous presses cancel out.
  always_comb begin
    dir = DirNone;
    if (exp_inc && !exp_dec) begin
      dir = DirUp;
    end else if (exp_dec && !exp_inc) begin
      dir = DirDn;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    ex_d    = ex_q;
    do_step = 1'b0;
    step_sz = (WIDTH + 1)'(1);
    sum     = '0;
    diff    = '0;

    if (lock) begin
      state_d = StLocked;
      timer_d = '0;
    end else if (state_q == StLocked) begin
      // Only a full release re-arms the buttons.
      if (dir == DirNone) begin
        state_d = StIdle;
      end
    end else if (recall) begin
      ex_d    = DefaultV;
      timer_d = '0;
      state_d = (dir == DirNone) ? StIdle : StLocked;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dir != DirNone) begin
            do_step = 1'b1;
            dir_d   = dir;
            state_d = StDelay;
            timer_d = DelayLoad;
          end
        end
        StDelay, StRepeat: begin
          if (dir == DirNone) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (dir != dir_q) begin
            do_step = 1'b1;
            dir_d   = dir;
            state_d = StDelay;
            timer_d = DelayLoad;
          end else if (timer_q == '0) begin
            do_step = 1'b1;
            state_d = StRepeat;
            timer_d = PeriodLoad;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

`ifdef EX_TIME_ACCEL_EN
    // Any step that lands in StRepeat is a repeat step.
    if (do_step && state_d == StRepeat && accel_q == AccelMax) begin
      step_sz = (WIDTH + 1)'(2);
    end
`endif

    sum  = {1'b0, ex_q} + step_sz;
    diff = {1'b0, ex_q} - step_sz;
    if (do_step) begin
      if (dir == DirUp) begin
        ex_d = (sum > MaxW) ? MaxV : sum[WIDTH-1:0];
      end else begin
        ex_d = ({1'b0, ex_q} < MinW + step_sz) ? MinV : diff[WIDTH-1:0];
      end
    end
  end

`ifdef EX_TIME_ACCEL_EN
  // Counts unit repeat steps; leaving StRepeat (release, new direction, lock, recall)
  // clears it.
  always_comb begin
    accel_d = '0;
    if (state_d == StRepeat) begin
      accel_d = accel_q;
      if (do_step && accel_q < AccelMax) begin
        accel_d = accel_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accel_q <= '0;
    end else begin
      accel_q <= accel_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      dir_q     <= DirNone;
      timer_q   <= '0;
      ex_q      <= DefaultV;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      ex_q      <= ex_d;
      changed_q <= (ex_d != ex_q);
    end
  end

  assign ex_time = ex_q;
  assign at_min  = (ex_q == MinV);
  assign at_max  = (ex_q == MaxV);
  assign changed = changed_q;

endmodule

// File: tb/tb_ex_time_ctrl.sv
module tb_ex_time_ctrl;

  logic       clk;
  logic       reset;
  logic       exp_inc;
  logic       exp_dec;
  logic       recall;
  logic       lock;
  logic [4:0] ex_time;
  logic       at_min;
  logic       at_max;
  logic       changed;

  int checks   = 0;
  int failures = 0;
  int pulses;

  ex_time_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .exp_inc (exp_inc),
    .exp_dec (exp_dec),
    .recall  (recall),
    .lock    (lock),
    .ex_time (ex_time),
    .at_min  (at_min),
    .at_max  (at_max),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected ex_time after hold edge i, holding exp_inc from 15 with default parameters.
`ifdef EX_TIME_ACCEL_EN
  int hold_exp[20] = '{16, 16, 16, 16, 16, 16, 16, 16, 17, 17,
                       18, 18, 19, 19, 20, 20, 22, 22, 24, 24};
`else
  int hold_exp[20] = '{16, 16, 16, 16, 16, 16, 16, 16, 17, 17,
                       18, 18, 19, 19, 20, 20, 21, 21, 22, 22};
`endif

  initial begin
    reset   = 1'b1;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    recall  = 1'b0;
    lock    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_ex_time", ex_time, 15);
    check("reset_changed", changed, 0);
    check("reset_at_min", at_min, 0);
    check("reset_at_max", at_max, 0);

    // Single-cycle presses.
    exp_inc = 1'b1;
    tick();
    check("inc_pulse_value", ex_time, 16);
    check("inc_pulse_changed", changed, 1);
    exp_inc = 1'b0;
    tick();
    check("inc_pulse_changed_drop", changed, 0);
    check("inc_pulse_hold_value", ex_time, 16);
    exp_dec = 1'b1;
    tick();
    check("dec_pulse_value", ex_time, 15);
    check("dec_pulse_changed", changed, 1);
    exp_dec = 1'b0;
    tick();

    // 20-cycle hold: steps at edges 0, 8, 10, ..., 18.
    pulses  = 0;
    exp_inc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hold_inc_edge%0d", i), ex_time, hold_exp[i]);
      if (changed) pulses++;
    end
    check("hold_inc_pulses", pulses, 7);
    exp_inc = 1'b0;
    tick();

    // Recall wins over a simultaneous press, and the held button is then ignored.
    recall  = 1'b1;
    exp_inc = 1'b1;
    tick();
    check("recall_value", ex_time, 15);
    check("recall_changed", changed, 1);
    recall = 1'b0;
    tick();
    tick();
    check("recall_held_no_step", ex_time, 15);
    exp_inc = 1'b0;
    tick();

    // Long decrement hold saturates at MIN and stops pulsing.
    exp_dec = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("dec_sat_value", ex_time, 2);
    check("dec_sat_at_min", at_min, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (changed) pulses++;
    end
    check("dec_sat_no_pulse", pulses, 0);
    check("dec_sat_still_min", ex_time, 2);
    exp_dec = 1'b0;
    tick();

    // Long increment hold saturates at MAX.
    exp_inc = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    check("inc_sat_value", ex_time, 30);
    check("inc_sat_at_max", at_max, 1);
    check("inc_sat_at_min", at_min, 0);
    check("inc_sat_changed", changed, 0);
    exp_inc = 1'b0;
    tick();
    recall = 1'b1;
    tick();
    recall = 1'b0;
    check("recall_idle_value", ex_time, 15);

    // Lock while holding, then unlock with the button still held.
    exp_inc = 1'b1;
    tick();
    check("lock_pre_step", ex_time, 16);
    lock = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("lock_frozen", ex_time, 16);
    lock = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("unlock_held_no_step", ex_time, 16);
    exp_inc = 1'b0;
    tick();
    exp_inc = 1'b1;
    tick();
    check("unlock_repress_value", ex_time, 17);
    check("unlock_repress_changed", changed, 1);
    exp_inc = 1'b0;
    tick();

    // Lock sampled on the same edge as a new press blocks the step.
    lock    = 1'b1;
    exp_dec = 1'b1;
    tick();
    check("lock_blocks_step", ex_time, 17);
    lock    = 1'b0;
    exp_dec = 1'b0;
    tick();

    // Both buttons together.
    exp_inc = 1'b1;
    exp_dec = 1'b1;
    tick();
    tick();
    tick();
    check("both_no_change", ex_time, 17);
    check("both_no_pulse", changed, 0);
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    tick();

    // Asynchronous reset mid-hold; the held button then acts as a new press.
    exp_inc = 1'b1;
    tick();
    check("pre_reset_step", ex_time, 18);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_value", ex_time, 15);
    check("async_reset_changed", changed, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_reset_press", ex_time, 16);
    check("post_reset_changed", changed, 1);
    exp_inc = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_time_ctrl.md
# ex_time_ctrl

Parametrised exposure-time controller for the digital camera. It holds the exposure setting selected by the user's increment/decrement buttons. Steps are saturating, and a held button auto-repeats. The setting is frozen while the exposure FSM is busy. `ex_time` feeds the exposure FSM's timer compare, and `changed` tells the display logic to refresh.

## Interface
Parameters:
- `WIDTH`, 5: width of `ex_time`.
- `MIN`, 2: lowest legal setting.
- `MAX`, 30: highest legal setting. Requires MIN <= DEFAULT <= MAX <= 2^WIDTH-1.
- `DEFAULT`, 15: value loaded on reset and on `recall`.
- `REPEAT_DELAY`, 8: cycles of continuous hold from the first step to the first repeat step. Must be >= 1.
- `REPEAT_PERIOD`, 2: cycles between subsequent repeat steps. Must be >= 1.
- `ACCEL_AFTER`, 4: number of unit repeat steps before step size doubles. Only used with `EX_TIME_ACCEL_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `exp_inc` in 1: increment button, level, synchronous, already debounced.
- `exp_dec` in 1: decrement button, level, synchronous, already debounced.
- `recall` in 1: synchronous single-cycle request to load `DEFAULT`.
- `lock` in 1: high while an exposure or readout is in progress. Freezes the setting.
- `ex_time` out WIDTH: current exposure setting, registered.
- `at_min` out 1: `ex_time == MIN`, decoded from the register.
- `at_max` out 1: `ex_time == MAX`, decoded from the register.
- `changed` out 1: one-cycle pulse, registered, on the edge where `ex_time` takes a new value.

## Operation
- Press direction each cycle: UP if inc & !dec, DN if dec & !inc, NONE otherwise. Both buttons pressed together counts as NONE.
- FSM states:
  - IDLE: on UP/DN, step once and go to DELAY. The timer loads REPEAT_DELAY-1.
  - DELAY: if the direction is unchanged, count down; at 0, step and go to REPEAT with the timer at REPEAT_PERIOD-1. A direction of NONE returns to IDLE. Any other direction is a new press: step immediately, stay in DELAY, and reload the timer.
  - REPEAT: step each time the timer reaches 0, then reload. Release and direction change are handled as in DELAY.
  - LOCKED: entered from any state on the edge where `lock` is sampled high. No steps and no recall are performed in this state. It leaves to IDLE only when `lock` is low and the direction is NONE, so a button held through the lock must be released and pressed again.
- Step arithmetic is saturating:
  - UP: `ex_time = min(ex_time + s, MAX)`.
  - DN: `ex_time = max(ex_time - s, MIN)`.
  - Step size s is 1, or 2 in the accelerated phase. The computation is done in WIDTH+1 bits, so it never wraps.
  - A step at the limit leaves the value unchanged and does not pulse `changed`. The FSM still advances normally.
- `recall` (when not locked) loads DEFAULT and has priority over a step in the same cycle. The FSM goes to IDLE if the direction is NONE, otherwise to LOCKED-style release-wait behaviour.
- Priority order: `reset` > `lock` > `recall` > step.

## Timing
- Reset values: `ex_time`=DEFAULT, `changed`=0, FSM=IDLE, timer=0, accelerate count=0. `at_min`/`at_max` reflect DEFAULT.
- Latency: a press first sampled at edge t0 updates `ex_time` at t0, so it is visible one cycle after the input is applied.
- Holding a button produces steps at t0, t0+REPEAT_DELAY, and t0+REPEAT_DELAY+k*REPEAT_PERIOD for k >= 1.
- `changed` is high for exactly the cycle following each value-changing edge.
- `lock` sampled high at edge t blocks any step at t.
- Reset asserted mid-hold immediately forces the reset values. After release, a still-held button is treated as a new press.

## Configuration
- `EX_TIME_ACCEL_EN` defined: in REPEAT, after ACCEL_AFTER unit repeat steps, s=2 until release or direction change. Release or direction change clears the counter.
- `EX_TIME_ACCEL_EN` undefined: s=1 always. No accelerate counter is synthesised.

## Test plan
- Reset with defaults -> `ex_time`=15, `changed`=0, `at_min`=0, `at_max`=0.
- Pulse `exp_inc` for 1 cycle -> `ex_time`=16 with one `changed` pulse. A 1-cycle `exp_dec` pulse then -> 15.
- Hold `exp_inc` 20 cycles -> steps at cycles 0, 8, 10, 12, 14, 16, 18, giving 22 without accel. With accel: 16, 17, 18, 19, 20, 22, 24.
- Hold `exp_dec` from 3 -> `ex_time` reaches 2, `at_min`=1, and `changed` stops pulsing while the hold continues. With accel, 3 - 2 saturates to 2.
- Raise `lock` while holding `exp_inc`, then drop `lock` with the button still held -> no change. Release, then press -> +1.
- Assert `exp_inc` and `exp_dec` together -> no change. Assert `recall` together with `exp_inc` at 20 -> 15.
